decode_queue: RTL



---
 rtl/decode_pkg.sv | 35 +++
 rtl/decode_fifo.sv | 76 +++++++
 rtl/decode_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcodes, instruction classes and the
// width of a queued decoded record.
package decode_pkg;

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [2:0] IC_R      = 3'd0;
   localparam logic [2:0] IC_I_ALU  = 3'd1;
   localparam logic [2:0] IC_LOAD   = 3'd2;
   localparam logic [2:0] IC_STORE  = 3'd3;
   localparam logic [2:0] IC_BRANCH = 3'd4;
   localparam logic [2:0] IC_JUMP   = 3'd5;
   localparam logic [2:0] IC_NONE   = 3'd7;

   // Record = instruction word + dest + reg_write + iclass + illegal, plus imm_ext and pc.
   localparam int REC_BASE_W = 32 + 5 + 1 + 3 + 1;

   function automatic int rec_w(input int data_w);
      return REC_BASE_W + 2 * data_w;
   endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; DEPTH must be a power of 2
// so the pointers wrap naturally.
module decode_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (PTR_W + 1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; the count gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes each accepted instruction and queues the record toward execute.
// Optional DECODE_ILLEGAL_TRAP_EN flags unknown opcodes as illegal (iclass 7).
module decode_queue
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        dest,
   output logic              reg_write,
   output logic [5:0]        func,
   output logic [4:0]        shamt,
   output logic [DATA_W-1:0] imm_ext,
   output logic [25:0]       jump_target,
   output logic [2:0]        iclass,
   output logic              illegal,
   output logic [DATA_W-1:0] pc_out
);

   localparam int REC_W = rec_w(DATA_W);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [4:0]        dec_dest;
   logic              dec_reg_write;
   logic [2:0]        dec_iclass;
   logic              dec_illegal;
   logic [DATA_W-1:0] dec_imm;
   logic [REC_W-1:0]  rec_in, rec_head, rec_vis;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   logic [31:0]       head_instr;

   always_comb begin
      dec_dest      = '0;
      dec_reg_write = 1'b0;
      dec_iclass    = IC_NONE;
      dec_illegal   = 1'b0;
      dec_imm       = DATA_W'($signed(instruction[15:0]));
      case (instruction[31:26])
         OP_R: begin
            dec_iclass    = IC_R;
            dec_dest      = instruction[15:11];
            dec_reg_write = 1'b1;
         end
         OP_J:            dec_iclass = IC_JUMP;
         OP_JAL: begin
            dec_iclass    = IC_JUMP;
            dec_dest      = 5'd31;
            dec_reg_write = 1'b1;
         end
         OP_BEQ, OP_BNE:  dec_iclass = IC_BRANCH;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            dec_iclass    = IC_I_ALU;
            dec_dest      = instruction[20:16];
            dec_reg_write = 1'b1;
            if (instruction[31:26] == OP_LUI)
               dec_imm = DATA_W'({instruction[15:0], 16'h0000});
            else if (instruction[31:26] inside {OP_ANDI, OP_ORI, OP_XORI})
               dec_imm = DATA_W'(instruction[15:0]);
         end
         OP_LW: begin
            dec_iclass    = IC_LOAD;
            dec_dest      = instruction[20:16];
            dec_reg_write = 1'b1;
         end
         OP_SW:           dec_iclass = IC_STORE;
         default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec_iclass  = IC_NONE;
            dec_illegal = 1'b1;
`else
            // Without the trap, unknown opcodes behave like a register-writing I-type ALU op.
            dec_iclass    = IC_I_ALU;
            dec_dest      = instruction[20:16];
            dec_reg_write = 1'b1;
`endif
         end
      endcase
   end

   assign rec_in = {pc, dec_imm, instruction, dec_dest, dec_reg_write, dec_iclass, dec_illegal};

   // in_ready depends only on the stored count, so back-pressure never races out_ready.
   assign in_ready  = !fifo_full;
   assign out_valid = (fifo_count != '0);

   decode_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (in_valid && in_ready),
      .pop   (out_valid && out_ready),
      .wdata (rec_in),
      .rdata (rec_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rec_vis = fifo_empty ? '0 : rec_head;
   assign {pc_out, imm_ext, head_instr, dest, reg_write, iclass, illegal} = rec_vis;

   assign opcode      = head_instr[31:26];
   assign rs          = head_instr[25:21];
   assign rt          = head_instr[20:16];
   assign shamt       = head_instr[10:6];
   assign func        = head_instr[5:0];
   assign jump_target = head_instr[25:0];

endmodule
